altivec_issue_queue: RTL and testbench

Parametrised issue queue and in-order completion tracker between the AltiVec instruction source and the vector execution unit. It buffers up to DEPTH instructions with their three source operands and issues them to the execution unit under a valid/ready handshake. It tracks up to MAXOUT in-flight operations and returns results in order, with an optional CR6 summary for record-form (rc) instructions. It replaces the single-shot go/busy coupling with queued, back-pressured issue and a flush capability.

---
 rtl/altivec_issue_pkg.sv | 33 +++
 rtl/altivec_issue_fifo.sv | 76 +++++++
 rtl/altivec_issue_queue.sv | 164 ++++++++++++++++
 tb/tb_altivec_issue_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/altivec_issue_pkg.sv
`default_nettype none
// ============================================================================
// altivec_issue_pkg : shared types, CR6 constants and helpers for the issue queue
// Revision 1.0
// ============================================================================
package altivec_issue_pkg;

    localparam int ISSUE_VW = 128;
    localparam int ISSUE_IW = 8;

    localparam int CR6_ALL_TRUE  = 3;
    localparam int CR6_ALL_FALSE = 1;

    typedef struct packed {
        logic [ISSUE_IW-1:0] ins;
        logic                rc;
        logic [ISSUE_VW-1:0] vra;
        logic [ISSUE_VW-1:0] vrb;
        logic [ISSUE_VW-1:0] vrc;
    } issue_entry_t;

    function automatic logic [3:0] cr6_of(input logic [ISSUE_VW-1:0] vec, input logic rc);
        logic [3:0] r;
        r = 4'b0000;
        if (rc) begin
            r[CR6_ALL_TRUE]  = &vec;
            r[CR6_ALL_FALSE] = ~|vec;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/altivec_issue_fifo.sv
`default_nettype none
// ============================================================================
// altivec_issue_fifo : synchronous FIFO with occupancy count and clear
// Revision 1.0
// ============================================================================
module altivec_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int              PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_C = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_C = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Full/empty come from the count; a push into a full FIFO is lost even if a pop coincides.
    assign w_push = push_i & ~clr_i & (count_q != FULL_C);
    assign w_pop  = pop_i  & ~clr_i & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/altivec_issue_queue.sv
`default_nettype none
// ============================================================================
// altivec_issue_queue : back-pressured AltiVec issue queue with in-order completion
// Revision 1.0
// ============================================================================
module altivec_issue_queue
    import altivec_issue_pkg::*;
#(
    parameter int VW     = ISSUE_VW,
    parameter int IW     = ISSUE_IW,
    parameter int DEPTH  = 4,
    parameter int MAXOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [IW-1:0] ins,
    input  logic          rc,
    input  logic [VW-1:0] vra,
    input  logic [VW-1:0] vrb,
    input  logic [VW-1:0] vrc,
    input  logic          flush,
    output logic          dut_busy,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [IW-1:0] ex_ins,
    output logic [VW-1:0] ex_vra,
    output logic [VW-1:0] ex_vrb,
    output logic [VW-1:0] ex_vrc,
    input  logic          ex_done,
    input  logic [VW-1:0] ex_vrt,
    output logic [VW-1:0] vrt,
    output logic          vrt_valid,
    output logic [3:0]    cr6
);

    localparam int             EW      = IW + 1 + 3 * VW;
    localparam int             QCW     = $clog2(DEPTH + 1);
    localparam int             OW      = $clog2(MAXOUT + 1);
    localparam logic [QCW-1:0] Q_FULL  = QCW'(DEPTH);
    localparam logic [OW-1:0]  OUT_MAX = OW'(MAXOUT);

    logic [EW-1:0]  w_enq_entry;
    logic [EW-1:0]  w_head_raw;
    logic [EW-1:0]  w_head;
    logic [QCW-1:0] w_q_count;
    logic           w_q_empty;
    logic           w_head_rc;
    logic           w_fire;
    logic           w_enq;
    logic           w_done;
    logic           w_deliver;
    logic           w_rc_head;
    logic [OW-1:0]  w_rc_count_unused;
    logic [3:0]     w_cr6;

    logic [OW-1:0]  out_q;
    logic [OW-1:0]  out_d;
    logic [OW-1:0]  drop_q;
    logic [OW-1:0]  drop_d;
    logic [VW-1:0]  vrt_q;
    logic           vrt_valid_q;
    logic [3:0]     cr6_q;

    assign w_enq_entry = {ins, rc, vra, vrb, vrc};
    assign w_q_empty   = (w_q_count == '0);
    assign dut_busy    = (w_q_count == Q_FULL);
    assign ex_valid    = ~w_q_empty & (out_q < OUT_MAX) & ~flush;
    assign w_fire      = ex_valid & ex_ready;
    assign w_enq       = go & ~dut_busy & ~flush;

    // Head is forced to zero while empty so stale storage never shows on ex_*.
    assign w_head = w_q_empty ? '0 : w_head_raw;
    assign {ex_ins, w_head_rc, ex_vra, ex_vrb, ex_vrc} = w_head;

    altivec_issue_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_issue_q (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .push_i  (w_enq),
        .pop_i   (w_fire),
        .data_i  (w_enq_entry),
        .data_o  (w_head_raw),
        .count_o (w_q_count)
    );

    altivec_issue_fifo #(
        .WIDTH (1),
        .DEPTH (MAXOUT)
    ) u_rc_q (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .push_i  (w_fire),
        .pop_i   (w_done),
        .data_i  (w_head_rc),
        .data_o  (w_rc_head),
        .count_o (w_rc_count_unused)
    );

    // A completion with nothing outstanding is a protocol error and is ignored.
    assign w_done    = ex_done & (out_q != '0);
    assign w_deliver = w_done & (drop_q == '0);

    generate
        if (VW == ISSUE_VW) begin : g_cr6_pkg
            assign w_cr6 = cr6_of(ex_vrt, w_rc_head);
        end else begin : g_cr6_generic
            always_comb begin
                w_cr6 = 4'b0000;
                if (w_rc_head) begin
                    w_cr6[CR6_ALL_TRUE]  = &ex_vrt;
                    w_cr6[CR6_ALL_FALSE] = ~|ex_vrt;
                end
            end
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        if (w_fire && !w_done) begin
            out_d = out_q + OW'(1);
        end else if (!w_fire && w_done) begin
            out_d = out_q - OW'(1);
        end
    end

    // On flush every op still in flight after this cycle's completion must be silenced.
    always_comb begin
        drop_d = drop_q;
        if (flush) begin
            drop_d = w_done ? (out_q - OW'(1)) : out_q;
        end else if (w_done && (drop_q != '0)) begin
            drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= '0;
            drop_q      <= '0;
            vrt_q       <= '0;
            vrt_valid_q <= 1'b0;
            cr6_q       <= 4'b0000;
        end else begin
            out_q       <= out_d;
            drop_q      <= drop_d;
            vrt_valid_q <= w_deliver;
            if (w_deliver) begin
                vrt_q <= ex_vrt;
                cr6_q <= w_cr6;
            end
        end
    end

    assign vrt       = vrt_q;
    assign vrt_valid = vrt_valid_q;
    assign cr6       = cr6_q;

endmodule
`default_nettype wire

// File: tb/tb_altivec_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_altivec_issue_queue : scoreboard bench with a queue-level reference model
// Revision 1.0
// ============================================================================
module tb_altivec_issue_queue;
    import altivec_issue_pkg::*;

    localparam int VW     = 128;
    localparam int IW     = 8;
    localparam int DEPTH  = 4;
    localparam int MAXOUT = 4;

    logic          clk;
    logic          rst;
    logic          go;
    logic [IW-1:0] ins;
    logic          rc;
    logic [VW-1:0] vra;
    logic [VW-1:0] vrb;
    logic [VW-1:0] vrc;
    logic          flush;
    logic          dut_busy;
    logic          ex_valid;
    logic          ex_ready;
    logic [IW-1:0] ex_ins;
    logic [VW-1:0] ex_vra;
    logic [VW-1:0] ex_vrb;
    logic [VW-1:0] ex_vrc;
    logic          ex_done;
    logic [VW-1:0] ex_vrt;
    logic [VW-1:0] vrt;
    logic          vrt_valid;
    logic [3:0]    cr6;

    altivec_issue_queue #(
        .VW     (VW),
        .IW     (IW),
        .DEPTH  (DEPTH),
        .MAXOUT (MAXOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .ins       (ins),
        .rc        (rc),
        .vra       (vra),
        .vrb       (vrb),
        .vrc       (vrc),
        .flush     (flush),
        .dut_busy  (dut_busy),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_ins    (ex_ins),
        .ex_vra    (ex_vra),
        .ex_vrb    (ex_vrb),
        .ex_vrc    (ex_vrc),
        .ex_done   (ex_done),
        .ex_vrt    (ex_vrt),
        .vrt       (vrt),
        .vrt_valid (vrt_valid),
        .cr6       (cr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic rc; bit doomed; } flight_t;
    typedef struct { logic [VW-1:0] v; logic [3:0] c; } res_t;

    // Reference model: queued instructions and in-flight ops, each op carrying its own fate.
    issue_entry_t m_q[$];
    flight_t      m_fl[$];
    issue_entry_t exp_issue_q[$];
    res_t         exp_res_q[$];

    bit exp_busy_now, exp_valid_now, exp_vv_now, pend_vv, last_fire, mon_en;
    int n_checks, n_err, n_fire, n_vv;
    issue_entry_t mon_e;
    res_t         mon_r;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: unexpected DUT output at %0t", nm, $time);
    endtask

    function automatic logic [3:0] ref_cr6(input logic r, input logic [VW-1:0] v);
        if (!r)               return 4'b0000;
        if (v == {VW{1'b1}})  return 4'b1000;
        if (v == '0)          return 4'b0010;
        return 4'b0000;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [VW-1:0] pick_vec();
        case ($urandom_range(0, 3))
            0:       return {VW{1'b1}};
            1:       return '0;
            2:       return VW'(1);
            default: return rnd_vec();
        endcase
    endfunction

    function automatic issue_entry_t rnd_entry();
        issue_entry_t e;
        e.ins = IW'($urandom());
        e.rc  = 1'($urandom());
        e.vra = rnd_vec();
        e.vrb = rnd_vec();
        e.vrc = rnd_vec();
        return e;
    endfunction

    // Apply one cycle of stimulus, advance the model, and return 1ns after the next edge.
    task automatic step(input bit g, input issue_entry_t e, input bit fl, input bit rdy,
                        input bit dn, input logic [VW-1:0] r);
        bit      fire;
        flight_t f;
        res_t    rs;
        go = g; ins = e.ins; rc = e.rc; vra = e.vra; vrb = e.vrb; vrc = e.vrc;
        flush = fl; ex_ready = rdy; ex_done = dn; ex_vrt = r;
        exp_vv_now    = pend_vv;
        pend_vv       = 1'b0;
        exp_busy_now  = (m_q.size() == DEPTH);
        exp_valid_now = (m_q.size() != 0) && (m_fl.size() < MAXOUT) && !fl;
        fire          = exp_valid_now && rdy;
        if (dn && m_fl.size() != 0) begin
            f = m_fl.pop_front();
            if (!f.doomed) begin
                rs.v = r;
                rs.c = ref_cr6(f.rc, r);
                exp_res_q.push_back(rs);
                pend_vv = 1'b1;
            end
        end
        if (fl) begin
            foreach (m_fl[i]) m_fl[i].doomed = 1'b1;
            m_q.delete();
        end else begin
            if (fire) begin
                exp_issue_q.push_back(m_q[0]);
                f.rc = m_q[0].rc;
                f.doomed = 1'b0;
                m_fl.push_back(f);
                void'(m_q.pop_front());
            end
            if (g && !exp_busy_now) m_q.push_back(e);
        end
        last_fire = fire;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy, input bit dn);
        step(1'b0, rnd_entry(), 1'b0, rdy, dn, rnd_vec());
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (m_q.size() != 0 || m_fl.size() != 0); i++) begin
            idle(1'b1, m_fl.size() != 0);
        end
        chk("drain_model_empty", VW'(m_q.size() + m_fl.size()), '0);
        idle(1'b0, 1'b0);
    endtask

    task automatic check_all_zero();
        chk("rst_dut_busy", dut_busy, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ins", ex_ins, 0);
        chk("rst_ex_vra", ex_vra, 0);
        chk("rst_ex_vrb", ex_vrb, 0);
        chk("rst_ex_vrc", ex_vrc, 0);
        chk("rst_vrt", vrt, 0);
        chk("rst_vrt_valid", vrt_valid, 0);
        chk("rst_cr6", cr6, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("dut_busy", dut_busy, exp_busy_now);
            chk("ex_valid", ex_valid, exp_valid_now);
            chk("vrt_valid", vrt_valid, exp_vv_now);
            if (ex_valid && ex_ready) begin
                n_fire++;
                if (exp_issue_q.size() == 0) begin
                    fail_now("issue_extra");
                end else begin
                    mon_e = exp_issue_q.pop_front();
                    chk("ex_ins", ex_ins, mon_e.ins);
                    chk("ex_vra", ex_vra, mon_e.vra);
                    chk("ex_vrb", ex_vrb, mon_e.vrb);
                    chk("ex_vrc", ex_vrc, mon_e.vrc);
                end
            end
            if (vrt_valid) begin
                n_vv++;
                if (exp_res_q.size() == 0) begin
                    fail_now("result_extra");
                end else begin
                    mon_r = exp_res_q.pop_front();
                    chk("vrt", vrt, mon_r.v);
                    chk("cr6", cr6, mon_r.c);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] pat [4];
        logic          prc [4];
        logic [3:0]    pcr [4];
        issue_entry_t  e;
        int            s;

        rst = 1'b0; go = 1'b0; ins = '0; rc = 1'b0; vra = '0; vrb = '0; vrc = '0;
        flush = 1'b0; ex_ready = 1'b0; ex_done = 1'b0; ex_vrt = '0;
        mon_en = 1'b0; pend_vv = 1'b0; last_fire = 1'b0;
        n_checks = 0; n_err = 0; n_fire = 0; n_vv = 0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b1;
        #1;
        mon_en = 1'b1;

        // Fill with backpressure, then release.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, rnd_vec());
            if (i >= 3) chk("fill_busy", dut_busy, 1);
        end
        s = n_fire;
        repeat (6) idle(1'b1, 1'b0);
        chk("fill_issue_count", VW'(n_fire - s), VW'(4));
        drain();

        // Outstanding limit.
        s = n_fire;
        repeat (6) step(1'b1, rnd_entry(), 1'b0, 1'b1, 1'b0, rnd_vec());
        repeat (2) idle(1'b1, 1'b0);
        chk("outlim_fires", VW'(n_fire - s), VW'(4));
        chk("outlim_stall", ex_valid, 0);
        step(1'b0, rnd_entry(), 1'b0, 1'b1, 1'b1, rnd_vec());
        idle(1'b1, 1'b0);
        chk("outlim_refire", VW'(n_fire - s), VW'(5));
        drain();

        // CR6 summaries.
        pat[0] = {VW{1'b1}}; prc[0] = 1'b1; pcr[0] = 4'b1000;
        pat[1] = '0;         prc[1] = 1'b1; pcr[1] = 4'b0010;
        pat[2] = VW'(1);     prc[2] = 1'b1; pcr[2] = 4'b0000;
        pat[3] = {VW{1'b1}}; prc[3] = 1'b0; pcr[3] = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            e = rnd_entry();
            e.rc = prc[i];
            step(1'b1, e, 1'b0, 1'b1, 1'b0, rnd_vec());
            idle(1'b1, 1'b0);
            step(1'b0, rnd_entry(), 1'b0, 1'b1, 1'b1, pat[i]);
            chk("cr6_pulse", vrt_valid, 1);
            chk("cr6_value", cr6, pcr[i]);
            chk("cr6_vrt", vrt, pat[i]);
        end
        drain();

        // Flush with 3 in flight, 2 queued, and a colliding go.
        repeat (4) step(1'b1, rnd_entry(), 1'b0, 1'b1, 1'b0, rnd_vec());
        step(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, rnd_vec());
        step(1'b1, rnd_entry(), 1'b1, 1'b1, 1'b0, rnd_vec());
        chk("flush_q_empty", ex_valid, 0);
        s = n_vv;
        repeat (3) step(1'b0, rnd_entry(), 1'b0, 1'b1, 1'b1, pick_vec());
        idle(1'b1, 1'b0);
        chk("flush_suppressed", VW'(n_vv - s), '0);
        step(1'b1, rnd_entry(), 1'b0, 1'b1, 1'b0, rnd_vec());
        idle(1'b1, 1'b0);
        step(1'b0, rnd_entry(), 1'b0, 1'b1, 1'b1, pick_vec());
        idle(1'b1, 1'b0);
        chk("flush_new_op", VW'(n_vv - s), VW'(1));
        drain();

        // Asynchronous reset with 2 in flight and 3 queued.
        repeat (3) step(1'b1, rnd_entry(), 1'b0, 1'b1, 1'b0, rnd_vec());
        repeat (2) step(1'b1, rnd_entry(), 1'b0, 1'b0, 1'b0, rnd_vec());
        go = 1'b0; flush = 1'b0; ex_ready = 1'b0; ex_done = 1'b0;
        mon_en = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_all_zero();
        m_q.delete(); m_fl.delete(); exp_issue_q.delete(); exp_res_q.delete();
        pend_vv = 1'b0; last_fire = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_ex_valid", ex_valid, 0);
        chk("post_rst_busy", dut_busy, 0);
        mon_en = 1'b1;

        // Streaming at full throughput.
        s = n_vv;
        for (int i = 0; i < 16; i++) step(1'b1, rnd_entry(), 1'b0, 1'b1, last_fire, pick_vec());
        repeat (3) step(1'b0, rnd_entry(), 1'b0, 1'b1, last_fire, pick_vec());
        chk("stream_pulses", VW'(n_vv - s), VW'(16));
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, rnd_entry(), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0,
                 (m_fl.size() != 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 7) == 0),
                 pick_vec());
        end
        drain();

        chk("sb_issue_left", VW'(exp_issue_q.size()), '0);
        chk("sb_result_left", VW'(exp_res_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
